// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU dispatch block: ALU control codes, RV32I opcode
// and funct3 values used by the decoder, and the dispatch FSM state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU control codes driven on alu_control
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // RV32I major opcodes handled by the dispatcher
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct3 values of interest
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // Dispatch FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_dispatch_decode.sv
// -----------------------------------------------------------------------------
// alu_dispatch_decode
// Combinational decode of opcode/funct3/funct7_5 into an ALU control code.
// Ports:
//   opcode, funct3, funct7_5 : instruction fields
//   control                  : ALU control code (ADD/SUB/AND/OR)
//   use_imm                  : operand 2 comes from the immediate, not rs2
//   is_beq, is_bne           : branch flavour, used to resolve taken/not-taken
//   illegal                  : unsupported opcode/funct combination
// -----------------------------------------------------------------------------
module alu_dispatch_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [2:0] control,
   output logic       use_imm,
   output logic       is_beq,
   output logic       is_bne,
   output logic       illegal
);

   always_comb begin
      control = ALU_ADD;
      use_imm = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_R: begin
            case (funct3)
               F3_ADD:  control = funct7_5 ? ALU_SUB : ALU_ADD;
               F3_AND:  control = ALU_AND;
               F3_OR:   control = ALU_OR;
               default: illegal = 1'b1;
            endcase
         end
         OP_I: begin
            // funct7_5 is deliberately ignored: no SUBI exists
            use_imm = 1'b1;
            case (funct3)
               F3_ADD:  control = ALU_ADD;
               F3_AND:  control = ALU_AND;
               F3_OR:   control = ALU_OR;
               default: illegal = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE: begin
            // address generation: rs1 + imm
            use_imm = 1'b1;
         end
         OP_BRANCH: begin
            // both compares use SUB so alu_zero tells equality
            control = ALU_SUB;
            case (funct3)
               F3_BEQ:  is_beq  = 1'b1;
               F3_BNE:  is_bne  = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_dispatch.sv
// -----------------------------------------------------------------------------
// alu_dispatch
// Initiator side of the ALU operand/control/done interface. Accepts one
// decoded instruction under valid/ready, drives registered operands and
// control to the ALU, waits for alu_done (bounded by TIMEOUT_CYCLES), then
// returns one response (result, branch outcome, illegal, timeout).
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   req_valid/req_ready              : request handshake
//   opcode, funct3, funct7_5         : instruction fields
//   rs1_data, rs2_data, imm          : operand sources
//   alu_in1, alu_in2, alu_control    : registered ALU drive
//   alu_out, alu_done, alu_zero      : ALU return
//   rsp_valid/rsp_ready              : response handshake
//   rsp_result, rsp_branch_taken,
//   rsp_illegal, rsp_timeout         : response fields
// Optional (macro ALU_DISPATCH_STATS_EN):
//   stat_ops [31:0]      : good completed responses
//   stat_timeouts [15:0] : timed-out responses
// -----------------------------------------------------------------------------
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [2:0]      alu_control,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_done,
   input  logic            alu_zero,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_branch_taken,
   output logic            rsp_illegal,
`ifdef ALU_DISPATCH_STATS_EN
   output logic [31:0]     stat_ops,
   output logic [15:0]     stat_timeouts,
`endif
   output logic            rsp_timeout
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_t     state_reg;
   logic [7:0] cnt_reg;
   logic [7:0] cnt_next;
   logic       is_beq_reg;
   logic       is_bne_reg;

   logic [2:0] dec_control;
   logic       dec_use_imm;
   logic       dec_is_beq;
   logic       dec_is_bne;
   logic       dec_illegal;

   alu_dispatch_decode u_decode (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .control  (dec_control),
      .use_imm  (dec_use_imm),
      .is_beq   (dec_is_beq),
      .is_bne   (dec_is_bne),
      .illegal  (dec_illegal)
   );

   assign cnt_next = cnt_reg + 8'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= '0;
         is_beq_reg       <= 1'b0;
         is_bne_reg       <= 1'b0;
         req_ready        <= 1'b1;
         alu_in1          <= '0;
         alu_in2          <= '0;
         alu_control      <= ALU_ADD;
         rsp_valid        <= 1'b0;
         rsp_result       <= '0;
         rsp_branch_taken <= 1'b0;
         rsp_illegal      <= 1'b0;
         rsp_timeout      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready        <= 1'b0;
                  rsp_result       <= '0;
                  rsp_branch_taken <= 1'b0;
                  rsp_timeout      <= 1'b0;
                  if (dec_illegal) begin
                     // ALU drive is left untouched for illegal requests
                     rsp_illegal <= 1'b1;
                     rsp_valid   <= 1'b1;
                     state_reg   <= ST_RESP;
                  end else begin
                     rsp_illegal <= 1'b0;
                     alu_in1     <= rs1_data;
                     alu_in2     <= dec_use_imm ? imm : rs2_data;
                     alu_control <= dec_control;
                     is_beq_reg  <= dec_is_beq;
                     is_bne_reg  <= dec_is_bne;
                     cnt_reg     <= '0;
                     state_reg   <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // alu_done is checked first so it wins over a coincident timeout
               if (alu_done) begin
                  rsp_result       <= alu_out;
                  rsp_branch_taken <= (is_beq_reg & alu_zero) | (is_bne_reg & ~alu_zero);
                  rsp_valid        <= 1'b1;
                  state_reg        <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_next;
                  if (cnt_next == TIMEOUT_LIM) begin
                     rsp_timeout <= 1'b1;
                     rsp_valid   <= 1'b1;
                     state_reg   <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               // req_ready rises only after the handshake edge, so no request
               // can be taken in the same cycle as the response
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_DISPATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_ops      <= '0;
         stat_timeouts <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (!rsp_illegal && !rsp_timeout) stat_ops <= stat_ops + 32'd1;
         if (rsp_timeout) stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// -----------------------------------------------------------------------------
// tb_alu_dispatch
// Self-checking bench for alu_dispatch (TIMEOUT_CYCLES = 4). A simple ALU
// model answers the DUT; expected values come from a decode table and plain
// arithmetic on the instruction's source operands.
// -----------------------------------------------------------------------------
module tb_alu_dispatch;

   localparam int XLEN = 32;
   localparam int TMO  = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [6:0]      opcode = '0;
   logic [2:0]      funct3 = '0;
   logic            funct7_5 = 1'b0;
   logic [XLEN-1:0] rs1_data = '0;
   logic [XLEN-1:0] rs2_data = '0;
   logic [XLEN-1:0] imm = '0;
   logic [XLEN-1:0] alu_in1;
   logic [XLEN-1:0] alu_in2;
   logic [2:0]      alu_control;
   logic [XLEN-1:0] alu_out;
   logic            alu_done = 1'b0;
   logic            alu_zero;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [XLEN-1:0] rsp_result;
   logic            rsp_branch_taken;
   logic            rsp_illegal;
   logic            rsp_timeout;
`ifdef ALU_DISPATCH_STATS_EN
   logic [31:0]     stat_ops;
   logic [15:0]     stat_timeouts;
   int              exp_ops = 0;
   int              exp_to = 0;
`endif

   int         n_cmp = 0;
   int         n_err = 0;
   logic [2:0] last_ctrl = 3'b000;

   always #5 clk = ~clk;

   alu_dispatch #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .opcode           (opcode),
      .funct3           (funct3),
      .funct7_5         (funct7_5),
      .rs1_data         (rs1_data),
      .rs2_data         (rs2_data),
      .imm              (imm),
      .alu_in1          (alu_in1),
      .alu_in2          (alu_in2),
      .alu_control      (alu_control),
      .alu_out          (alu_out),
      .alu_done         (alu_done),
      .alu_zero         (alu_zero),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_result       (rsp_result),
      .rsp_branch_taken (rsp_branch_taken),
      .rsp_illegal      (rsp_illegal),
`ifdef ALU_DISPATCH_STATS_EN
      .stat_ops         (stat_ops),
      .stat_timeouts    (stat_timeouts),
`endif
      .rsp_timeout      (rsp_timeout)
   );

   // Environment ALU: answers whatever the DUT drives
   logic [XLEN-1:0] alu_model;
   always_comb begin
      alu_model = '0;
      case (alu_control)
         3'b000:  alu_model = alu_in1 + alu_in2;
         3'b001:  alu_model = alu_in1 - alu_in2;
         3'b010:  alu_model = alu_in1 & alu_in2;
         3'b011:  alu_model = alu_in1 | alu_in2;
         default: alu_model = '0;
      endcase
   end
   assign alu_out  = alu_model;
   assign alu_zero = (alu_model == '0);

   // Reference decode table. br: 0 none, 1 BEQ, 2 BNE
   function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                      output bit ill, output logic [2:0] ctl, output bit ui, output int br);
      ill = 1'b0; ctl = 3'b000; ui = 1'b0; br = 0;
      if (op == 7'b0110011) begin
         if (f3 == 3'b000) ctl = f75 ? 3'b001 : 3'b000;
         else if (f3 == 3'b111) ctl = 3'b010;
         else if (f3 == 3'b110) ctl = 3'b011;
         else ill = 1'b1;
      end else if (op == 7'b0010011) begin
         ui = 1'b1;
         if (f3 == 3'b000) ctl = 3'b000;
         else if (f3 == 3'b111) ctl = 3'b010;
         else if (f3 == 3'b110) ctl = 3'b011;
         else ill = 1'b1;
      end else if (op == 7'b0000011 || op == 7'b0100011) begin
         ui = 1'b1;
      end else if (op == 7'b1100011) begin
         ctl = 3'b001;
         if (f3 == 3'b000) br = 1;
         else if (f3 == 3'b001) br = 2;
         else ill = 1'b1;
      end else begin
         ill = 1'b1;
      end
   endfunction

   // One full transaction. done_delay: WAIT cycles before alu_done (-1 never).
   // rdy_delay: cycles rsp_ready is held low while a competing request is offered.
   task automatic do_op(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input int done_delay, input int rdy_delay);
      bit ill, ui, taken, tmo;
      logic [2:0] ctl;
      int br, waits, exp_waits;
      logic [31:0] in2, res;
      ref_decode(op, f3, f75, ill, ctl, ui, br);
      in2 = ui ? im : b;
      case (ctl)
         3'b000:  res = a + in2;
         3'b001:  res = a - in2;
         3'b010:  res = a & in2;
         default: res = a | in2;
      endcase
      taken = (br == 1 && a == b) || (br == 2 && a != b);
      tmo = !ill && (done_delay < 0 || done_delay >= TMO);
      if (ill || tmo) begin res = '0; taken = 1'b0; end

      @(negedge clk);
      req_valid = 1'b1; opcode = op; funct3 = f3; funct7_5 = f75;
      rs1_data = a; rs2_data = b; imm = im;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;

      if (!ill) begin
         n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL %s wait_flags: valid %b ready %b want 0 0", name, rsp_valid, req_ready); end
         n_cmp++; if (alu_control !== ctl) begin n_err++; $display("FAIL %s alu_control: got %b want %b", name, alu_control, ctl); end
         n_cmp++; if (alu_in1 !== a) begin n_err++; $display("FAIL %s alu_in1: got %h want %h", name, alu_in1, a); end
         n_cmp++; if (alu_in2 !== in2) begin n_err++; $display("FAIL %s alu_in2: got %h want %h", name, alu_in2, in2); end
         last_ctrl = ctl;
         exp_waits = tmo ? TMO : done_delay + 1;
         waits = 0;
         while (1) begin
            alu_done = (waits == done_delay);
            @(posedge clk);
            waits++;
            @(negedge clk);
            if (rsp_valid === 1'b1 || waits > TMO + 4) break;
            n_cmp++; if (alu_in2 !== in2 || alu_control !== ctl) begin n_err++; $display("FAIL %s wait_hold: in2 %h ctl %b want %h %b", name, alu_in2, alu_control, in2, ctl); end
         end
         alu_done = 1'b0;
         n_cmp++; if (waits !== exp_waits) begin n_err++; $display("FAIL %s wait_cycles: got %0d want %0d", name, waits, exp_waits); end
      end

      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL %s rsp_valid: got %b want 1", name, rsp_valid); end
      n_cmp++; if (rsp_illegal !== ill) begin n_err++; $display("FAIL %s rsp_illegal: got %b want %b", name, rsp_illegal, ill); end
      n_cmp++; if (rsp_timeout !== tmo) begin n_err++; $display("FAIL %s rsp_timeout: got %b want %b", name, rsp_timeout, tmo); end
      n_cmp++; if (rsp_result !== res) begin n_err++; $display("FAIL %s rsp_result: got %h want %h", name, rsp_result, res); end
      n_cmp++; if (rsp_branch_taken !== taken) begin n_err++; $display("FAIL %s branch_taken: got %b want %b", name, rsp_branch_taken, taken); end
      n_cmp++; if (alu_control !== last_ctrl) begin n_err++; $display("FAIL %s alu_control_resp: got %b want %b", name, alu_control, last_ctrl); end

      // Hold off the response while a new request is offered
      req_valid = 1'b1;
      for (int i = 0; i < rdy_delay; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== res || req_ready !== 1'b0) begin
            n_err++; $display("FAIL %s resp_hold: valid %b result %h ready %b want 1 %h 0", name, rsp_valid, rsp_result, req_ready, res);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL %s after_handshake: valid %b ready %b want 0 1", name, rsp_valid, req_ready); end
      req_valid = 1'b0;
`ifdef ALU_DISPATCH_STATS_EN
      if (!ill && !tmo) exp_ops++;
      if (tmo) exp_to++;
      n_cmp++; if (stat_ops !== 32'(exp_ops) || stat_timeouts !== 16'(exp_to)) begin
         n_err++; $display("FAIL %s stats: ops %0d to %0d want %0d %0d", name, stat_ops, stat_timeouts, exp_ops, exp_to);
      end
`endif
      $display("txn %s op=%b f3=%b f75=%b a=%h b=%h imm=%h -> res=%h taken=%b ill=%b tmo=%b", name, op, f3, f75, a, b, im, res, taken, ill, tmo);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_ctrl = 3'b000;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (alu_in1 !== '0 || alu_in2 !== '0) begin n_err++; $display("FAIL reset alu_in: got %h %h want 0 0", alu_in1, alu_in2); end
      n_cmp++; if (alu_control !== 3'b000) begin n_err++; $display("FAIL reset alu_control: got %b want 000", alu_control); end
      n_cmp++; if (rsp_result !== '0) begin n_err++; $display("FAIL reset rsp_result: got %h want 0", rsp_result); end
      n_cmp++; if ({rsp_branch_taken, rsp_illegal, rsp_timeout} !== 3'b000) begin
         n_err++; $display("FAIL reset rsp_flags: got %b want 000", {rsp_branch_taken, rsp_illegal, rsp_timeout});
      end
`ifdef ALU_DISPATCH_STATS_EN
      exp_ops = 0; exp_to = 0;
      n_cmp++; if (stat_ops !== 32'd0 || stat_timeouts !== 16'd0) begin n_err++; $display("FAIL reset stats: got %0d %0d want 0 0", stat_ops, stat_timeouts); end
`endif
      $display("txn reset done");
   endtask

   task automatic test_illegal();
      do_op("illegal_system", 7'b1110011, 3'b000, 1'b0, 32'h11, 32'h22, 32'h33, 0, 0);
      do_op("illegal_rtype_f3", 7'b0110011, 3'b100, 1'b0, 32'h1, 32'h2, 32'h0, 0, 1);
      do_op("illegal_branch_f3", 7'b1100011, 3'b100, 1'b0, 32'h5, 32'h5, 32'h0, 0, 0);
   endtask

   task automatic test_r_add();
      do_op("r_add", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 0, 0);
      do_op("r_sub", 7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd99, 1, 0);
      do_op("i_or", 7'b0010011, 3'b110, 1'b1, 32'hF0F0_0000, 32'd7, 32'h0000_0F0F, 0, 0);
      do_op("store_addr", 7'b0100011, 3'b010, 1'b0, 32'h1000, 32'd7, 32'hFFFF_FFFC, 2, 0);
   endtask

   task automatic test_branch();
      do_op("beq_equal", 7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'h0, 0, 0);
      do_op("bne_equal", 7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1234, 32'h0, 0, 0);
      do_op("bne_diff", 7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1235, 32'h0, 1, 0);
   endtask

   task automatic test_timeout();
      do_op("timeout", 7'b0110011, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'h0, -1, 0);
      do_op("done_at_limit", 7'b0110011, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'h0, TMO - 1, 0);
   endtask

   task automatic test_back_to_back();
      do_op("backpressure", 7'b0000011, 3'b010, 1'b0, 32'h200, 32'h0, 32'h10, 0, 5);
      do_op("back_to_back", 7'b0110011, 3'b110, 1'b0, 32'hA5, 32'h5A, 32'h0, 0, 0);
   endtask

   task automatic test_random();
      logic [6:0] op_tab [6];
      logic [6:0] op;
      int dd;
      op_tab[0] = 7'b0110011; op_tab[1] = 7'b0010011; op_tab[2] = 7'b0000011;
      op_tab[3] = 7'b0100011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b0000000;
      for (int i = 0; i < 40; i++) begin
         op = op_tab[$urandom_range(0, 5)];
         if (op == 7'b0000000) op = 7'($urandom);
         dd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
         do_op("random", op, 3'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 32'h77 : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'h77 : $urandom,
               $urandom, dd, int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      req_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b110; funct7_5 = 1'b0;
      rs1_data = 32'h3; rs2_data = 32'h4; alu_done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_ctrl = 3'b000;
      n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid flags: ready %b valid %b want 1 0", req_ready, rsp_valid); end
      n_cmp++; if (alu_control !== 3'b000 || alu_in1 !== '0) begin n_err++; $display("FAIL reset_mid alu: ctl %b in1 %h want 000 0", alu_control, alu_in1); end
`ifdef ALU_DISPATCH_STATS_EN
      exp_ops = 0; exp_to = 0;
      n_cmp++; if (stat_ops !== 32'd0 || stat_timeouts !== 16'd0) begin n_err++; $display("FAIL reset_mid stats: got %0d %0d want 0 0", stat_ops, stat_timeouts); end
`endif
      seen = 1'b0;
      alu_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      alu_done = 1'b0;
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid dropped_rsp: rsp_valid seen %b want 0", seen); end
      $display("txn reset_mid done");
      do_op("after_reset", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_r_add();
      test_branch();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t", $time);
      $fatal(1, "time limit");
   end

endmodule
